// File: rtl/tug_pkg.sv
// Shared types, constants and the score display decode for the tug-of-war match.
package tug_pkg;

    localparam int SCORE_W         = 4;
    localparam int DEF_HALF        = 4;
    localparam int DEF_WIN_SCORE   = 7;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        PLAY         = 2'd0,
        WAIT_RELEASE = 2'd1,
        MATCH_DONE   = 2'd2
    } state_t;

    // Active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7_n(input logic [SCORE_W-1:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/press_sync.sv
// Button conditioner: synchronise a raw active-low key, then emit one
// registered single-cycle pulse per press.
module press_sync
    import tug_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed_prev_q;
    logic                   press_q;

    assign pressed = ~sync_q[SYNC_STAGES-1];
    assign press   = press_q;

    // Synchroniser chain and rising-edge detector, all cleared to "released".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q         <= '1;
            pressed_prev_q <= 1'b0;
            press_q        <= 1'b0;
        end else begin
            sync_q         <= {sync_q[SYNC_STAGES-2:0], key_n};
            pressed_prev_q <= pressed;
            press_q        <= pressed & ~pressed_prev_q;
        end
    end

endmodule

// File: rtl/tug_of_war_match.sv
// Tug-of-war match controller: a light pulled left/right by two buttons,
// a point scored when it is pulled off an end, first to WIN_SCORE wins.
//
// state        | meaning
// PLAY         | presses move the light or score a point
// WAIT_RELEASE | after reset or a point; waits for both keys released
// MATCH_DONE   | a player reached WIN_SCORE; everything frozen until reset
module tug_of_war_match
    import tug_pkg::*;
#(
    parameter int HALF        = DEF_HALF,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l_key_n,
    input  logic               r_key_n,
    output logic [2*HALF:0]    leds,
    output logic [SCORE_W-1:0] l_score,
    output logic [SCORE_W-1:0] r_score,
    output logic               point,
    output logic               match_over,
    output logic               winner,
    output logic [6:0]         hex_l,
    output logic [6:0]         hex_r
);

    localparam int                  POS_W       = $clog2(2*HALF+1);
    localparam logic [POS_W-1:0]    POS_MAX     = POS_W'(2*HALF);
    localparam logic [POS_W-1:0]    POS_MID     = POS_W'(HALF);
    localparam logic [SCORE_W-1:0]  WIN         = SCORE_W'(WIN_SCORE);
    localparam int                  SETTLE_W    = $clog2(SYNC_STAGES+1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SYNC_STAGES);

    logic l_pressed, l_press, r_pressed, r_press;

    state_t               state_q, state_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [SCORE_W-1:0]   l_score_q, l_score_d, r_score_q, r_score_d;
    logic                 point_q, point_d;
    logic                 match_over_q, match_over_d;
    logic                 winner_q, winner_d;
    logic [SETTLE_W-1:0]  settle_q;

    press_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
        .clk     (clk),
        .reset   (reset),
        .key_n   (l_key_n),
        .pressed (l_pressed),
        .press   (l_press)
    );

    press_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
        .clk     (clk),
        .reset   (reset),
        .key_n   (r_key_n),
        .pressed (r_pressed),
        .press   (r_press)
    );

    // A key held through reset only shows up after the synchroniser refills,
    // so WAIT_RELEASE is not allowed to exit until this timer has expired.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q <= SETTLE_LOAD;
        end else if (settle_q != '0) begin
            settle_q <= settle_q - 1'b1;
        end
    end

    // Match state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_RELEASE;
            pos_q        <= POS_MID;
            l_score_q    <= '0;
            r_score_q    <= '0;
            point_q      <= 1'b0;
            match_over_q <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            l_score_q    <= l_score_d;
            r_score_q    <= r_score_d;
            point_q      <= point_d;
            match_over_q <= match_over_d;
            winner_q     <= winner_d;
        end
    end

    // Next-state and scoring decisions.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        point_d   = 1'b0;
        winner_d  = winner_q;

        case (state_q)
            PLAY: begin
                if (l_press && !r_press) begin
                    if (pos_q == POS_MAX) begin
                        l_score_d = l_score_q + 1'b1;
                        point_d   = 1'b1;
                        pos_d     = POS_MID;
                        if (l_score_d == WIN) begin
                            state_d  = MATCH_DONE;
                            winner_d = 1'b1;
                        end else begin
                            state_d = WAIT_RELEASE;
                        end
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else if (r_press && !l_press) begin
                    if (pos_q == '0) begin
                        r_score_d = r_score_q + 1'b1;
                        point_d   = 1'b1;
                        pos_d     = POS_MID;
                        if (r_score_d == WIN) begin
                            state_d  = MATCH_DONE;
                            winner_d = 1'b0;
                        end else begin
                            state_d = WAIT_RELEASE;
                        end
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!l_pressed && !r_pressed && settle_q == '0) begin
                    state_d = PLAY;
                end
            end
            MATCH_DONE: begin
            end
            default: begin
                state_d = WAIT_RELEASE;
            end
        endcase

        match_over_d = (state_d == MATCH_DONE);
    end

    assign leds       = {{(2*HALF){1'b0}}, 1'b1} << pos_q;
    assign l_score    = l_score_q;
    assign r_score    = r_score_q;
    assign point      = point_q;
    assign match_over = match_over_q;
    assign winner     = winner_q;
    assign hex_l      = seg7_n(l_score_q);
    assign hex_r      = seg7_n(r_score_q);

endmodule

// File: tb/tb_tug_of_war_match.sv
// Bench for tug_of_war_match: directed scenarios plus a randomized press
// sequence compared against a transaction-level game model.
module tb_tug_of_war_match;

    localparam int H  = 4;
    localparam int WS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       l_key_n = 1'b1, r_key_n = 1'b1;
    logic [2*H:0] leds;
    logic [3:0] l_score, r_score;
    logic       point, match_over, winner;
    logic [6:0] hex_l, hex_r;

    logic       s_l_key_n = 1'b1, s_r_key_n = 1'b1;
    logic [2:0] s_leds;
    logic [3:0] s_l_score, s_r_score;
    logic       s_point, s_match_over, s_winner;
    logic [6:0] s_hex_l, s_hex_r;

    tug_of_war_match #(.HALF(H), .WIN_SCORE(WS), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .l_key_n(l_key_n), .r_key_n(r_key_n),
        .leds(leds), .l_score(l_score), .r_score(r_score), .point(point),
        .match_over(match_over), .winner(winner), .hex_l(hex_l), .hex_r(hex_r)
    );

    tug_of_war_match #(.HALF(1), .WIN_SCORE(WS), .SYNC_STAGES(3)) dut_s (
        .clk(clk), .reset(reset), .l_key_n(s_l_key_n), .r_key_n(s_r_key_n),
        .leds(s_leds), .l_score(s_l_score), .r_score(s_r_score), .point(s_point),
        .match_over(s_match_over), .winner(s_winner), .hex_l(s_hex_l), .hex_r(s_hex_r)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-low segment patterns for digits 0..F, {g,f,e,d,c,b,a}.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Game model: one call per completed press transaction.
    int m_pos, m_l, m_r, m_pts, m_over, m_win;

    task automatic model_reset();
        m_pos = H; m_l = 0; m_r = 0; m_over = 0; m_win = 0;
    endtask

    task automatic model_press(input int side);
        if (m_over != 0 || side == 2) return;
        if (side == 0) begin
            if (m_pos == 2*H) begin
                m_l++; m_pts++; m_pos = H;
                if (m_l == WS) begin m_over = 1; m_win = 1; end
            end else m_pos++;
        end else begin
            if (m_pos == 0) begin
                m_r++; m_pts++; m_pos = H;
                if (m_r == WS) begin m_over = 1; m_win = 0; end
            end else m_pos--;
        end
    endtask

    // Count point pulses and make sure each lasts one cycle.
    int   pt_seen = 0;
    logic prev_point = 1'b0;
    always @(negedge clk) begin
        if (point) begin
            pt_seen++;
            chk("point_one_cycle", prev_point, 0);
        end
        prev_point = point;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int side, input logic v);
        if (side == 0 || side == 2) l_key_n = v;
        if (side == 1 || side == 2) r_key_n = v;
    endtask

    task automatic do_press(input int side);
        int hold, gap;
        hold = $urandom_range(3, 8);
        gap  = $urandom_range(4, 8);
        drive(side, 1'b0);
        tick(hold);
        drive(side, 1'b1);
        tick(gap);
        model_press(side);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":leds"},    leds, 1 << m_pos);
        chk({tag, ":l_score"}, l_score, m_l);
        chk({tag, ":r_score"}, r_score, m_r);
        chk({tag, ":over"},    match_over, m_over);
        if (m_over != 0) chk({tag, ":winner"}, winner, m_win);
        chk({tag, ":hex_l"},   hex_l, seg_tab[m_l]);
        chk({tag, ":hex_r"},   hex_r, seg_tab[m_r]);
        chk({tag, ":points"},  pt_seen, m_pts);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":leds"},   leds, 9'b000010000);
        chk({tag, ":l"},      l_score, 0);
        chk({tag, ":r"},      r_score, 0);
        chk({tag, ":point"},  point, 0);
        chk({tag, ":over"},   match_over, 0);
        chk({tag, ":winner"}, winner, 0);
        chk({tag, ":hex_l"},  hex_l, 7'b1000000);
        chk({tag, ":hex_r"},  hex_r, 7'b1000000);
        chk({tag, ":s_leds"}, s_leds, 3'b010);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(4);
    endtask

    initial begin
        int side, r;
        model_reset();
        m_pts = 0;

        // Power-on reset values.
        tick(3);
        check_reset("reset");
        reset = 1'b0;
        tick(4);

        // Left key held through reset must not count.
        l_key_n = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model_reset();
        tick(10);
        chk("held_reset:leds", leds, 9'b000010000);
        l_key_n = 1'b1;
        tick(5);
        do_press(0);
        chk("held_reset:press", leds, 9'b000100000);
        check_all("held_reset");

        // Latency: leds change on the 4th edge after the key falls.
        l_key_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("latency_before", leds, 1 << m_pos);
        end
        tick(1);
        chk("latency_at_4", leds, 1 << (m_pos + 1));
        l_key_n = 1'b1;
        tick(6);
        model_press(0);
        check_all("latency");

        // Walk left to the end and score; right presses ignored while left held.
        do_reset();
        for (int i = 0; i < 4; i++) do_press(0);
        chk("walk:end", leds, 9'b100000000);
        l_key_n = 1'b0;
        tick(6);
        model_press(0);
        chk("walk:centre", leds, 9'b000010000);
        chk("walk:l_score", l_score, 1);
        r_key_n = 1'b0;
        tick(6);
        r_key_n = 1'b1;
        tick(6);
        l_key_n = 1'b1;
        tick(6);
        check_all("walk_wait_release");

        // Simultaneous presses change nothing.
        do_press(1);
        do_press(2);
        check_all("both");

        // Right wins the match; the result then stays frozen.
        do_reset();
        for (int i = 0; i < 15; i++) do_press(1);
        chk("rwin:r_score", r_score, 3);
        chk("rwin:over", match_over, 1);
        chk("rwin:winner", winner, 0);
        chk("rwin:hex_r", hex_r, 7'b0110000);
        for (int i = 0; i < 4; i++) do_press($urandom_range(0, 1));
        check_all("rwin_frozen");

        // Reset in the middle of a match.
        do_reset();
        for (int i = 0; i < 13; i++) do_press(0);
        chk("mid:l_score", l_score, 2);
        chk("mid:leds", leds, 1 << 7);
        reset = 1'b1;
        tick(1);
        check_reset("mid_reset");
        reset = 1'b0;
        model_reset();
        tick(4);

        // Randomized play against the model.
        for (int t = 0; t < 120; t++) begin
            r = $urandom_range(0, 4);
            side = (r < 2) ? 0 : (r < 4) ? 1 : 2;
            do_press(side);
            check_all("rand");
            if (m_over != 0 && $urandom_range(0, 2) == 0) do_reset();
        end

        // Narrow playfield with a deeper synchroniser: 5-edge latency.
        do_reset();
        s_l_key_n = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("small_latency_before", s_leds, 3'b010);
        end
        tick(1);
        chk("small_latency_at_5", s_leds, 3'b100);
        s_l_key_n = 1'b1;
        tick(8);
        s_l_key_n = 1'b0;
        tick(6);
        s_l_key_n = 1'b1;
        tick(8);
        chk("small:l_score", s_l_score, 1);
        chk("small:leds", s_leds, 3'b010);
        chk("small:r_score", s_r_score, 0);
        chk("small:over", s_match_over, 0);
        chk("small:hex_l", s_hex_l, 7'b1111001);
        chk("small:hex_r", s_hex_r, 7'b1000000);
        chk("small:point", s_point, 0);
        chk("small:winner", s_winner, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
